// File: rtl/data_bridge_if.sv
// Data-side bus between the core M stage and data_bridge.
// The core drives address, write data and byte enables; the bridge returns
// combinational read data in the same cycle.
interface data_bridge_if;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        input  m_data_rdata
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        output m_data_rdata
    );
endinterface

// File: rtl/data_bridge.sv
// data_bridge: data memory plus an optional memory-mapped timer.
// DM occupies word addresses below DM_WORDS (0x0000..0x2FFF by default);
// the timer exposes CTRL 0x7F00, PRESET 0x7F04 and COUNT 0x7F08.
// Build option: define DATA_BRIDGE_TIMER_EN to compile the timer in; without
// it the timer window reads as unmapped and irq is tied low.
module data_bridge #(
    parameter int DM_WORDS = 3072
) (
    input  logic         clk,
    input  logic         reset,
    data_bridge_if.slave bus,
    output logic         irq
);
    localparam int IDX_W = $clog2(DM_WORDS);

    logic [31:0]         dm [DM_WORDS];
    logic [DM_WORDS-1:0] dm_vld;
    logic                dm_sel;
    logic                dm_we;
    logic [IDX_W-1:0]    dm_idx;
    logic [31:0]         dm_word;
    logic [31:0]         dm_merged;
    logic                unused_lsb;

    // Byte offset bits never affect decode or read data.
    assign unused_lsb = ^bus.m_data_addr[1:0];

    assign dm_sel  = (bus.m_data_addr[31:2] < 30'(DM_WORDS));
    assign dm_idx  = bus.m_data_addr[IDX_W+1:2];
    assign dm_we   = dm_sel && (bus.m_data_byteen != 4'b0000);
    // A word never written since reset reads as zero, so the array itself
    // needs no reset and stays RAM-friendly.
    assign dm_word = dm_vld[dm_idx] ? dm[dm_idx] : 32'h0;

    // Merge enabled write lanes into the current word contents.
    always_comb begin
        dm_merged = dm_word;
        for (int b = 0; b < 4; b++) begin
            if (bus.m_data_byteen[b]) begin
                dm_merged[8*b +: 8] = bus.m_data_wdata[8*b +: 8];
            end
        end
    end

    // DM storage write; whole merged word is written back.
    always_ff @(posedge clk) begin
        if (dm_we) begin
            dm[dm_idx] <= dm_merged;
        end
    end

    // Per-word written flags; clearing them makes DM read as zero after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dm_vld <= '0;
        end else if (dm_we) begin
            dm_vld[dm_idx] <= 1'b1;
        end
    end

`ifdef DATA_BRIDGE_TIMER_EN
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} tmr_state_t;

    localparam logic [29:0] CTRL_WA   = 30'h1FC0;
    localparam logic [29:0] PRESET_WA = 30'h1FC1;
    localparam logic [29:0] COUNT_WA  = 30'h1FC2;

    tmr_state_t  state, state_nxt;
    logic [3:0]  ctrl, ctrl_nxt;
    logic [31:0] preset, preset_nxt;
    logic [31:0] count, count_nxt;
    logic        int_flag, int_nxt;
    logic [29:0] wa;
    logic        wr_ctrl, wr_preset;

    assign wa        = bus.m_data_addr[31:2];
    assign wr_ctrl   = (bus.m_data_byteen == 4'b1111) && (wa == CTRL_WA);
    assign wr_preset = (bus.m_data_byteen == 4'b1111) && (wa == PRESET_WA);

    // Timer state and register file, including the registered irq.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= 4'h0;
            preset   <= 32'h0;
            count    <= 32'h0;
            int_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            state    <= state_nxt;
            ctrl     <= ctrl_nxt;
            preset   <= preset_nxt;
            count    <= count_nxt;
            int_flag <= int_nxt;
            irq      <= int_nxt & ctrl_nxt[3];
        end
    end

    // Timer next-state: FSM progress first, then CPU writes override it.
    always_comb begin
        state_nxt  = state;
        ctrl_nxt   = ctrl;
        preset_nxt = preset;
        count_nxt  = count;
        int_nxt    = int_flag;
        case (state)
            IDLE: begin
                if (ctrl[0]) state_nxt = LOAD;
            end
            LOAD: begin
                count_nxt = preset;
                state_nxt = CNT;
            end
            CNT: begin
                if (!ctrl[0]) begin
                    state_nxt = IDLE;
                end else if (count > 32'd1) begin
                    count_nxt = count - 32'd1;
                end else begin
                    // A PRESET of 0 lands here on the first CNT cycle too.
                    count_nxt = 32'h0;
                    int_nxt   = 1'b1;
                    state_nxt = INT;
                end
            end
            INT: begin
                state_nxt = IDLE;
                if (ctrl[2:1] == 2'b01) begin
                    int_nxt = 1'b0;
                end else begin
                    ctrl_nxt[0] = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (wr_ctrl) begin
            ctrl_nxt  = bus.m_data_wdata[3:0];
            int_nxt   = 1'b0;
            state_nxt = IDLE;
        end
        if (wr_preset) begin
            preset_nxt = bus.m_data_wdata;
            int_nxt    = 1'b0;
            state_nxt  = IDLE;
        end
    end

    // Read mux: DM, timer registers, or zero for unmapped space.
    always_comb begin
        bus.m_data_rdata = 32'h0;
        if (dm_sel) begin
            bus.m_data_rdata = dm_word;
        end else begin
            case (wa)
                CTRL_WA:   bus.m_data_rdata = {28'h0, ctrl};
                PRESET_WA: bus.m_data_rdata = preset;
                COUNT_WA:  bus.m_data_rdata = count;
                default:   bus.m_data_rdata = 32'h0;
            endcase
        end
    end
`else
    assign irq = 1'b0;

    // Read mux: DM or zero for everything else, timer window included.
    always_comb begin
        bus.m_data_rdata = dm_sel ? dm_word : 32'h0;
    end
`endif

endmodule

// File: tb/tb_data_bridge.sv
// Testbench for data_bridge: directed scenarios plus randomized bus traffic,
// checked by a scoreboard against a behavioural model of memory and timer.
module tb_data_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic irq;

    data_bridge_if bus();

    data_bridge #(.DM_WORDS(3072)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

`ifdef DATA_BRIDGE_TIMER_EN
    localparam bit TMR = 1'b1;
`else
    localparam bit TMR = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          chk = 1'b0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [31:0] dm_m [3072];
    logic [3:0]  t_ctrl;
    logic [31:0] t_preset;
    logic [31:0] t_base;   // COUNT value left at the last forcing write
    int unsigned t_e;      // edge number of the last forcing write

    function automatic int unsigned p1();
        return (t_preset == 0) ? 1 : t_preset;
    endfunction

    function automatic bit is_auto();
        return t_ctrl[2:1] == 2'b01;
    endfunction

    // n = clock edges since the last forcing write (state IDLE at n = 0)
    function automatic logic [31:0] m_count(input int unsigned n);
        int unsigned per, m;
        if (!t_ctrl[0] || n < 2) return t_base;
        if (is_auto()) begin
            per = p1() + 3;
            m = n % per;
            if (m < 2) return 32'h0;
            if (m <= 1 + p1()) return t_preset - (m - 2);
            return 32'h0;
        end
        if (n <= 1 + p1()) return t_preset - (n - 2);
        return 32'h0;
    endfunction

    function automatic logic m_int(input int unsigned n);
        if (!t_ctrl[0]) return 1'b0;
        if (is_auto()) return (n % (p1() + 3)) == 2 + p1();
        return n >= 2 + p1();
    endfunction

    function automatic logic [3:0] m_ctrl(input int unsigned n);
        if (t_ctrl[0] && !is_auto() && n >= 3 + p1()) return t_ctrl & 4'hE;
        return t_ctrl;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int unsigned n;
        logic [3:0] c;
        n = cyc - t_e;
        if (a < 32'h3000) return dm_m[a[13:2]];
        if (TMR) begin
            c = m_ctrl(n);
            case (a[31:2])
                30'h1FC0: return {28'h0, c};
                30'h1FC1: return t_preset;
                30'h1FC2: return m_count(n);
                default:  return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    function automatic logic m_irq();
        int unsigned n;
        logic [3:0] c;
        n = cyc - t_e;
        c = m_ctrl(n);
        return TMR && m_int(n) && c[3];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3072; i++) dm_m[i] = 32'h0;
        t_ctrl = 4'h0;
        t_preset = 32'h0;
        t_base = 32'h0;
        t_e = cyc;
    endtask

    // Apply a write that took effect at edge number k.
    task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input int unsigned k);
        logic [3:0]  nc;
        logic [31:0] np, nb;
        if (a < 32'h3000) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) dm_m[a[13:2]][8*b +: 8] = d[8*b +: 8];
        end else if (TMR && be == 4'hF && (a[31:2] == 30'h1FC0 || a[31:2] == 30'h1FC1)) begin
            nc = (a[31:2] == 30'h1FC0) ? d[3:0] : m_ctrl(k - t_e);
            np = (a[31:2] == 30'h1FC1) ? d : t_preset;
            nb = m_count(k - t_e);
            t_ctrl = nc;
            t_preset = np;
            t_base = nb;
            t_e = k;
        end
    endtask

    // ---------------- bus driver ----------------
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.m_data_addr = a;
        bus.m_data_wdata = d;
        bus.m_data_byteen = be;
        @(posedge clk);
        #1;
        model_write(a, d, be, cyc);
        bus.m_data_byteen = 4'h0;
    endtask

    task automatic rd(input string nm, input logic [31:0] a);
        bus.m_data_addr = a;
        bus.m_data_byteen = 4'h0;
        sb.push_back('{nm, m_read(a), m_irq()});
        chk = 1'b1;
        @(posedge clk);
        #1;
        chk = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned s;
        s = $urandom_range(0, 9);
        if (s < 6) return {22'h0, 5'($urandom_range(0, 31)), 5'($urandom)};
        if (s < 8) return 32'($urandom_range(0, 32'h2FFF));
        if (s < 9) return 32'($urandom_range(32'h3000, 32'h7EFF));
        return 32'h0001_0000 | 32'($urandom);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (chk) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: output presented with no expected entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.m_data_rdata !== e.rd || irq !== e.irq) begin
                    errors++;
                    $display("FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                             e.name, bus.m_data_rdata, irq, e.rd, e.irq);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.m_data_addr = 32'h0;
        bus.m_data_wdata = 32'h0;
        bus.m_data_byteen = 4'h0;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        rd("reset_dm0", 32'h0000_0000);
        rd("reset_count", 32'h0000_7F08);
        rd("reset_ctrl", 32'h0000_7F00);
        #2 reset = 1'b1;
        @(posedge clk); #1;

        // lane writes
        wr(32'h0000_0010, 32'hAABB_CCDD, 4'b1111);
        rd("dm_full_write", 32'h0000_0010);
        wr(32'h0000_0010, 32'h1111_1111, 4'b0010);
        rd("dm_lane1_write", 32'h0000_0013);
        wr(32'h0000_2FFC, 32'h1234_5678, 4'b1001);
        rd("dm_top_word", 32'h0000_2FFC);

        // unmapped space
        wr(32'h0000_0000, 32'hCAFE_F00D, 4'b1111);
        rd("unmapped_4000", 32'h0000_4000);
        rd("unmapped_7F0C", 32'h0000_7F0C);
        wr(32'h0000_4000, 32'hDEAD_BEEF, 4'b1111);
        rd("dm0_after_unmapped_wr", 32'h0000_0000);
        rd("unmapped_3000", 32'h0000_3000);

        // one-shot with interrupt mask set
        wr(32'h0000_7F04, 32'd3, 4'b1111);
        wr(32'h0000_7F04, 32'hFFFF_FFFF, 4'b0011);
        rd("preset_partial_ignored", 32'h0000_7F04);
        wr(32'h0000_7F00, 32'h9, 4'b1111);
        for (int i = 0; i < 9; i++) rd("oneshot_count", 32'h0000_7F08);
        rd("oneshot_ctrl", 32'h0000_7F00);
        wr(32'h0000_7F08, 32'h55, 4'b1111);
        rd("count_write_ignored", 32'h0000_7F08);
        wr(32'h0000_7F00, 32'h0, 4'b1111);
        rd("irq_cleared", 32'h0000_7F00);

        // auto-reload
        wr(32'h0000_7F04, 32'd2, 4'b1111);
        wr(32'h0000_7F00, 32'hB, 4'b1111);
        for (int i = 0; i < 16; i++) rd("autoreload", 32'h0000_7F08);

        // preset 0 behaves as 1
        wr(32'h0000_7F04, 32'd0, 4'b1111);
        wr(32'h0000_7F00, 32'h9, 4'b1111);
        for (int i = 0; i < 6; i++) rd("preset0", 32'h0000_7F08);

        // reset mid-count
        wr(32'h0000_7F04, 32'd8, 4'b1111);
        wr(32'h0000_7F00, 32'h9, 4'b1111);
        for (int i = 0; i < 5; i++) rd("precount", 32'h0000_7F08);
        #2 reset = 1'b0;
        model_reset();
        rd("midreset_count", 32'h0000_7F08);
        rd("midreset_ctrl", 32'h0000_7F00);
        rd("midreset_dm", 32'h0000_0010);
        #2 reset = 1'b1;
        for (int i = 0; i < 12; i++) rd("post_reset", 32'h0000_7F08);

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            int unsigned op;
            logic [31:0] a;
            op = $urandom_range(0, 9);
            if (op < 4) begin
                a = rand_addr();
                wr(a, $urandom, 4'($urandom));
            end else if (op < 7) begin
                a = rand_addr();
                rd("rand_read", a);
            end else if (op == 7) begin
                wr(32'h0000_7F04, 32'($urandom_range(0, 5)),
                   ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
            end else if (op == 8) begin
                wr(32'h0000_7F00, $urandom,
                   ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
            end else begin
                rd("rand_timer", 32'h0000_7F00 + 32'(4 * $urandom_range(0, 2)));
            end
        end

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_bridge.md
DATA_BRIDGE -- requirements
Module: data_bridge

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port m_data_addr  input  32  byte address from core M stage.
REQ-004 SHALL have port m_data_wdata  input  32  write data, already lane-replicated by core.
REQ-005 SHALL have port m_data_byteen  input  4  per-byte write enable; 4'b0000 = read/no write.
REQ-006 SHALL have port m_data_rdata  output  32  combinational read data for m_data_addr (word-aligned).
REQ-007 SHALL have port irq  output  1  timer interrupt request, registered.
REQ-008 SHALL have parameter DM_WORDS, default 3072, DM depth in 32-bit words.

Function
REQ-009 SHALL decode DM at 0x0000_0000..0x0000_2FFF, timer CTRL 0x7F00, PRESET 0x7F04, COUNT 0x7F08; all other addresses unmapped.
REQ-010 SHALL index DM by m_data_addr[13:2]; addr[1:0] ignored for decode and read.
REQ-011 SHALL write DM byte lane i on the clock edge when byteen[i]=1, DM selected; other lanes unchanged.
REQ-012 SHALL return DM word, timer register, or 32'h0 (unmapped) on m_data_rdata in the same cycle, no wait states.
REQ-013 SHALL make reads see pre-edge contents: a write is visible on m_data_rdata from the cycle after its edge.
REQ-014 SHALL accept timer register writes only when byteen=4'b1111; partial writes to timer space ignored.
REQ-015 SHALL ignore writes to COUNT and to unmapped addresses.
REQ-016 SHALL implement CTRL[0]=enable, CTRL[2:1]=mode (00 one-shot, 01 auto-reload, others = one-shot), CTRL[3]=IM; CTRL[31:4] read 0.
REQ-017 SHALL implement timer FSM states IDLE, LOAD, CNT, INT.
REQ-018 IDLE: enable=1 -> LOAD next edge; else stay.
REQ-019 LOAD: COUNT<=PRESET, -> CNT.
REQ-020 CNT: enable=0 -> IDLE, COUNT held; COUNT>1 -> COUNT-1; COUNT<=1 -> COUNT<=0, set int flag, -> INT.
REQ-021 INT, one-shot: clear CTRL[0], -> IDLE, int flag held until CTRL or PRESET written.
REQ-022 INT, auto-reload: -> IDLE, enable kept (reload follows), int flag cleared after exactly one cycle.
REQ-023 SHALL, on accepted CTRL or PRESET write, update the register, clear int flag, force state IDLE at that edge; CPU write wins over simultaneous FSM CTRL[0] clear.
REQ-024 SHALL drive irq = int flag AND CTRL[3], both registered.
REQ-025 PRESET=0 SHALL behave as PRESET=1 (interrupt after one CNT cycle).

Reset
REQ-026 reset=0 SHALL immediately set CTRL, PRESET, COUNT, int flag to 0, state IDLE, irq 0, independent of clk.
REQ-027 DM contents SHALL be zero after reset; reset asserted mid-count aborts count with no irq.
REQ-028 First accepted write SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-029 Macro DATA_BRIDGE_TIMER_EN defined: timer compiled in per REQ-014..025.
REQ-030 Macro undefined: no timer logic; 0x7F00..0x7F0B treated as unmapped (read 0, writes ignored); irq tied 0.

Verification
REQ-031 Write 0xAABBCCDD to 0x0010 byteen 1111, then byteen 0010 data 0x11111111 -> read 0x0010 = 0xAABB11DD.
REQ-032 Read 0x4000 and 0x7F0C -> 0x00000000; write to 0x4000 then read DM 0x0000 unchanged.
REQ-033 PRESET=3, CTRL=0x9 -> COUNT 3,2,1 then 0, irq=1 held, CTRL[0] reads 0; write CTRL=0 -> irq 0 next cycle.
REQ-034 PRESET=2, CTRL=0xB -> irq pulses one cycle every 5 cycles (LOAD,CNT,CNT,INT,IDLE), repeating.
REQ-035 Mid-count (COUNT=5) assert reset=0 between edges -> CTRL/COUNT/irq 0 immediately; no irq after release.
REQ-036 Write PRESET with byteen 0011 -> PRESET unchanged; build without DATA_BRIDGE_TIMER_EN -> 0x7F04 reads 0, irq stays 0.
